// File: rtl/rf_pkg.sv
// Shared register-file constants, write-back request type and the one-hot
// destination decoder used by the write-back arbiter and register-file enables.
package rf_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned XLEN      = 32;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] decode5to32(input logic [REG_IDX_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted req at or after ptr
// (wrapping modulo N) wins, reported as a one-hot gnt plus its index.
module rr_arbiter #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    always_comb begin
        int unsigned k;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = W'(k);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among write-back
// requesters, with a one-cycle registered output. WB_FWD_EN adds bypass ports.
module rf_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    flush,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ*rf_pkg::REG_IDX_W-1:0]    req_rd,
    input  logic [NUM_REQ*XLEN-1:0]                 req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic                                    reg_write,
    output logic [rf_pkg::NUM_REGS-1:0]             wr_sel,
    output logic [XLEN-1:0]                         wb_data,
    output logic [PTR_W-1:0]                        grant_id
`ifdef WB_FWD_EN
    ,
    input  logic [rf_pkg::REG_IDX_W-1:0]            fwd_rs1_sel,
    input  logic [rf_pkg::REG_IDX_W-1:0]            fwd_rs2_sel,
    output logic                                    fwd_rs1_hit,
    output logic                                    fwd_rs2_hit,
    output logic [XLEN-1:0]                         fwd_data
`endif
);

    import rf_pkg::*;

    logic [PTR_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   req_eligible;
    logic [NUM_REQ-1:0]   gnt;
    logic [PTR_W-1:0]     gnt_idx;
    logic [REG_IDX_W-1:0] rd_sel;
    logic [XLEN-1:0]      data_sel;

    // Nothing is granted while flushing or held in reset.
    assign req_eligible = (flush || !reset_n) ? '0 : req_valid;

    rr_arbiter #(
        .N (NUM_REQ),
        .W (PTR_W)
    ) u_rr_arbiter (
        .req     (req_eligible),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    always_comb begin
        rd_sel   = '0;
        data_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                rd_sel   = req_rd[i*REG_IDX_W +: REG_IDX_W];
                data_sel = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            reg_write <= 1'b0;
            wr_sel    <= '0;
            wb_data   <= '0;
            grant_id  <= '0;
        end else if (|gnt) begin
            rr_ptr    <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            // x0 writes are consumed but never strobe the register file.
            reg_write <= |rd_sel;
            wr_sel    <= decode5to32(rd_sel) & ~NUM_REGS'(1);
            wb_data   <= data_sel;
            grant_id  <= gnt_idx;
        end else begin
            reg_write <= 1'b0;
            wr_sel    <= '0;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_rs1_hit = reg_write & wr_sel[fwd_rs1_sel];
    assign fwd_rs2_hit = reg_write & wr_sel[fwd_rs2_sel];
    assign fwd_data    = wb_data;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed rows push expected values,
// a negedge monitor pops and compares them against the DUT.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        reg_write;
    logic [31:0] wr_sel;
    logic [31:0] wb_data;
    logic [1:0]  grant_id;

    typedef struct {
        int          row;
        logic [2:0]  ready;
        logic        rw;
        logic [31:0] sel;
        logic [31:0] data;
        logic [1:0]  gid;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   row_n  = 0;
    bit   done   = 1'b0;

    rf_wb_arbiter #(
        .NUM_REQ (3),
        .XLEN    (32),
        .PTR_W   (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_write (reg_write),
        .wr_sel    (wr_sel),
        .wb_data   (wb_data),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("req_ready", e.row, 32'(req_ready), 32'(e.ready));
                chk("reg_write", e.row, 32'(reg_write), 32'(e.rw));
                chk("wr_sel",    e.row, wr_sel,         e.sel);
                chk("wb_data",   e.row, wb_data,        e.data);
                chk("grant_id",  e.row, 32'(grant_id),  32'(e.gid));
                checks++;
                if ($countones(req_ready) > 1 || $countones(wr_sel) > 1 || wr_sel[0] ||
                    (reg_write != |wr_sel)) begin
                    errors++;
                    $display("FAIL invariant row %0d: ready=%b wr_sel=0x%08h reg_write=%b",
                             e.row, req_ready, wr_sel, reg_write);
                end
            end
        end
    end

    // One row: drive inputs just after the edge, expect ready for these inputs
    // and the registered outputs produced by the previous edge.
    task automatic step(input logic rn, input logic fl, input logic [2:0] v,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [2:0] er, input logic erw, input logic [31:0] es,
                        input logic [31:0] ed, input logic [1:0] eg);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = rn;
        flush     = fl;
        req_valid = v;
        req_rd    = {r2, r1, r0};
        req_data  = {d2, d1, d0};
        e.row   = row_n;
        e.ready = er;
        e.rw    = erw;
        e.sel   = es;
        e.data  = ed;
        e.gid   = eg;
        q.push_back(e);
        row_n++;
    endtask

    initial begin
        reset_n   = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        #1 reset_n = 1'b0;
        //   rn fl  valid  rd0 rd1 rd2  d0        d1            d2         ready  rw  sel           data          gid
        step(0, 0, 3'b000, 0,  0,  0,  32'h0,    32'h0,        32'h0,     3'b000, 0, 32'h0,        32'h0,        0);
        // single requester 1
        step(1, 0, 3'b010, 0,  5,  0,  32'h0,    32'hDEADBEEF, 32'h0,     3'b010, 0, 32'h0,        32'h0,        0);
        step(1, 0, 3'b000, 0,  5,  0,  32'h0,    32'hDEADBEEF, 32'h0,     3'b000, 1, 32'h20,       32'hDEADBEEF, 1);
        // wrap-around from rr_ptr=2
        step(1, 0, 3'b101, 3,  0,  7,  32'hA0,   32'h0,        32'hC2,    3'b100, 0, 32'h0,        32'hDEADBEEF, 1);
        step(1, 0, 3'b001, 3,  0,  7,  32'hA0,   32'h0,        32'hC2,    3'b001, 1, 32'h80,       32'hC2,       2);
        // x0 write
        step(1, 0, 3'b001, 0,  0,  0,  32'h1234, 32'h0,        32'h0,     3'b001, 1, 32'h8,        32'hA0,       0);
        step(1, 0, 3'b100, 0,  0,  9,  32'h1234, 32'h0,        32'h99,    3'b100, 0, 32'h0,        32'h1234,     0);
        // fairness, all valid from rr_ptr=0
        step(1, 0, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b001, 1, 32'h200,      32'h99,       2);
        step(1, 0, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b010, 1, 32'h2,        32'h10,       0);
        step(1, 0, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b100, 1, 32'h4,        32'h11,       1);
        step(1, 0, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b001, 1, 32'h80000000, 32'h12,       2);
        step(1, 0, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b010, 1, 32'h2,        32'h10,       0);
        // flush two cycles, in-flight beat still completes
        step(1, 1, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b000, 1, 32'h4,        32'h11,       1);
        step(1, 1, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b000, 0, 32'h0,        32'h11,       1);
        step(1, 0, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b100, 0, 32'h0,        32'h11,       1);
        step(1, 0, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b001, 1, 32'h80000000, 32'h12,       2);
        // reset mid-stream while reg_write=1, outputs clear before the next edge
        step(0, 0, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b000, 0, 32'h0,        32'h0,        0);
        step(1, 0, 3'b111, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b001, 0, 32'h0,        32'h0,        0);
        step(1, 0, 3'b000, 1,  2,  31, 32'h10,   32'h11,       32'h12,    3'b000, 1, 32'h2,        32'h10,       0);
        done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (done);
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
